// File: rtl/vga_scan_controller.sv
`default_nettype none
// ============================================================================
// Module  : vga_scan_controller
// Brief   : VGA row/col scan generator with vblank-only frame-buffer write
//           arbitration. Define VGA_FRAME_COUNTER_EN to add frame_count[7:0].
// Revision: 1.0 - initial release
// ============================================================================
module vga_scan_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int CLK_DIV  = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] row,
  output logic [9:0] col,
  output logic       pixel_tick,
  output logic       active,
  output logic       frame_start,
  input  logic       update_req,
  output logic       update_grant,
  input  logic       update_done,
`ifdef VGA_FRAME_COUNTER_EN
  output logic       update_overrun,
  output logic [7:0] frame_count
`else
  output logic       update_overrun
`endif
);

  localparam logic [9:0] c_h_active = 10'(H_ACTIVE);
  localparam logic [9:0] c_v_active = 10'(V_ACTIVE);
  localparam logic [9:0] c_h_last   = 10'(H_TOTAL - 1);
  localparam logic [9:0] c_v_last   = 10'(V_TOTAL - 1);
  localparam logic [9:0] c_v_pre    = 10'(V_ACTIVE - 1);
  localparam logic [1:0] c_div_last = 2'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_GRANT = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_div;
  logic [1:0] w_div_next;
  logic       w_line_end;
  logic       w_vblank_start;
  logic       w_frame_end;

  assign w_div_next     = (r_div == c_div_last) ? 2'd0 : r_div + 2'd1;
  assign w_line_end     = pixel_tick && (col == c_h_last);
  assign w_vblank_start = w_line_end && (row == c_v_pre);
  assign w_frame_end    = w_line_end && (row == c_v_last);
  assign active         = (row < c_v_active) && (col < c_h_active);

  // pixel_tick is decoded from the next divider value so it is high exactly
  // while the divider sits at CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div       <= 2'd0;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
      row         <= 10'd0;
      col         <= 10'd0;
    end else begin
      r_div       <= w_div_next;
      pixel_tick  <= (w_div_next == c_div_last);
      frame_start <= w_frame_end;
      if (pixel_tick) begin
        if (col == c_h_last) begin
          col <= 10'd0;
          row <= (row == c_v_last) ? 10'd0 : row + 10'd1;
        end else begin
          col <= col + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      update_grant   <= 1'b0;
      update_overrun <= 1'b0;
    end else begin
      update_overrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (update_req) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!update_req) begin
            r_state <= S_IDLE;
          end else if (w_vblank_start) begin
            r_state      <= S_GRANT;
            update_grant <= 1'b1;
          end
        end
        S_GRANT: begin
          // done takes priority over a coincident frame wrap
          if (update_done) begin
            r_state      <= S_IDLE;
            update_grant <= 1'b0;
          end else if (w_frame_end) begin
            r_state        <= S_IDLE;
            update_grant   <= 1'b0;
            update_overrun <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          update_grant <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= 8'd0;
    end else if (w_frame_end) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_controller.sv
`default_nettype none
// Testbench for vga_scan_controller: reduced raster, directed scenarios plus
// random request/done/reset traffic checked against a positional model.
module tb_vga_scan_controller;

  localparam int HA = 8;
  localparam int HT = 12;
  localparam int VA = 6;
  localparam int VT = 10;
  localparam int D  = 3;
  localparam int F  = HT * VT;

  logic       clk = 1'b0;
  logic       reset;
  logic       update_req;
  logic       update_done;
  logic [9:0] row;
  logic [9:0] col;
  logic       pixel_tick;
  logic       active;
  logic       frame_start;
  logic       update_grant;
  logic       update_overrun;
`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] frame_count;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model state: p = linear raster position, k = clocks since reset release
  int k;
  int p;
  bit m_tick;
  bit m_fs;
  bit m_grant;
  bit m_wait;
  bit m_over;
  int m_fc;
  int m_row;
  int m_col;
  assign m_row = p / HT;
  assign m_col = p % HT;

  always #5 clk = ~clk;

  vga_scan_controller #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT), .CLK_DIV(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row(row),
    .col(col),
    .pixel_tick(pixel_tick),
    .active(active),
    .frame_start(frame_start),
    .update_req(update_req),
    .update_grant(update_grant),
    .update_done(update_done),
    .update_overrun(update_overrun)
`ifdef VGA_FRAME_COUNTER_EN
    ,
    .frame_count(frame_count)
`endif
  );

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) begin : model
    bit adv, vstart, wrap, g, w, o;
    int np;
    if (reset) begin
      k <= 0; p <= 0; m_tick <= 0; m_fs <= 0;
      m_grant <= 0; m_wait <= 0; m_over <= 0; m_fc <= 0;
    end else begin
      adv    = m_tick;
      vstart = adv && (p == VA * HT - 1);
      wrap   = adv && (p == F - 1);
      g = m_grant; w = m_wait; o = 1'b0;
      if (m_grant) begin
        if (update_done) g = 1'b0;
        else if (wrap) begin g = 1'b0; o = 1'b1; end
      end else if (m_wait) begin
        if (!update_req) w = 1'b0;
        else if (vstart) begin w = 1'b0; g = 1'b1; end
      end else if (update_req) begin
        w = 1'b1;
      end
      np = adv ? (p + 1) % F : p;
      p       <= np;
      m_grant <= g;
      m_wait  <= w;
      m_over  <= o;
      m_fs    <= wrap;
      if (wrap) m_fc <= (m_fc + 1) % 256;
      k      <= k + 1;
      m_tick <= (((k + 1) % D) == D - 1);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("row", int'(row), m_row);
      chk("col", int'(col), m_col);
      chk("pixel_tick", int'(pixel_tick), int'(m_tick));
      chk("frame_start", int'(frame_start), int'(m_fs));
      chk("active", int'(active), int'(m_row < VA && m_col < HA));
      chk("update_grant", int'(update_grant), int'(m_grant));
      chk("update_overrun", int'(update_overrun), int'(m_over));
      chk("grant_during_active", int'(update_grant && active), 0);
`ifdef VGA_FRAME_COUNTER_EN
      chk("frame_count", int'(frame_count), m_fc);
`endif
    end
  end

  task automatic wait_at(input int r, input int c);
    int n = 0;
    while (!(m_row == r && m_col == c) && n < 2 * F * D) begin
      @(negedge clk);
      n++;
    end
    chk("wait_at_reached", int'(m_row == r && m_col == c), 1);
  endtask

  task automatic wait_grant();
    int n = 0;
    while (!update_grant && n < 3 * F * D) begin
      @(negedge clk);
      n++;
    end
    chk("grant_rose", int'(update_grant), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ov;
    int n;
    reset = 1'b1; update_req = 1'b0; update_done = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_row", int'(row), 0);
    chk("rst_col", int'(col), 0);
    chk("rst_grant", int'(update_grant), 0);
`ifdef VGA_FRAME_COUNTER_EN
    chk("rst_frame_count", int'(frame_count), 0);
`endif

    // divider of 3: first column advance lands on the third clock
    repeat (3) @(negedge clk);
    chk("col_after_3clk", int'(col), 1);
    chk("model_col_after_3clk", m_col, 1);
    repeat (33) @(negedge clk);
    chk("row_after_line", int'(row), 1);
    chk("col_after_line", int'(col), 0);
    chk("model_row_after_line", m_row, 1);
    repeat (324) @(negedge clk);
    chk("frame_start_after_frame", int'(frame_start), 1);
    chk("model_fs_after_frame", int'(m_fs), 1);
    chk("row_wrap", int'(row), 0);
    chk("col_wrap", int'(col), 0);
`ifdef VGA_FRAME_COUNTER_EN
    chk("frame_count_one", int'(frame_count), 1);
`endif

    // request during active video, finish during blanking
    wait_at(2, 3);
    update_req = 1'b1;
    wait_grant();
    chk("grant_row", int'(row), VA);
    chk("grant_col", int'(col), 0);
    update_req = 1'b0;
    wait_at(7, 2);
    update_done = 1'b1;
    @(negedge clk);
    update_done = 1'b0;
    chk("grant_after_done", int'(update_grant), 0);
    chk("no_overrun_after_done", int'(update_overrun), 0);

    // never finish: grant revoked at wrap with one overrun pulse
    wait_at(1, 0);
    update_req = 1'b1;
    wait_grant();
    update_req = 1'b0;
    ov = 0;
    repeat (F * D) begin
      @(negedge clk);
      ov += int'(update_overrun);
    end
    chk("overrun_pulses", ov, 1);
    chk("grant_after_overrun", int'(update_grant), 0);

    // done on the same edge as the wrap: no overrun
    wait_at(0, 0);
    update_req = 1'b1;
    wait_grant();
    update_req = 1'b0;
    wait_at(VT - 1, HT - 1);
    n = 0;
    while (!m_tick && n < D + 1) begin
      @(negedge clk);
      n++;
    end
    update_done = 1'b1;
    @(negedge clk);
    update_done = 1'b0;
    chk("coincident_no_overrun", int'(update_overrun), 0);
    chk("coincident_grant_low", int'(update_grant), 0);
    chk("coincident_row0", int'(row), 0);

    // request first raised inside vblank waits for the next frame
    wait_at(8, 0);
    update_req = 1'b1;
    wait_at(0, 0);
    chk("no_mid_blank_grant", int'(update_grant), 0);
    wait_grant();
    chk("late_req_grant_row", int'(row), VA);
    update_req = 1'b0;

    // reset while granted late in blanking
    wait_at(9, 2);
    chk("grant_before_reset", int'(update_grant), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_grant", int'(update_grant), 0);
    chk("reset_row", int'(row), 0);
    chk("reset_col", int'(col), 0);
    chk("reset_overrun", int'(update_overrun), 0);
    reset = 1'b0;

    // random traffic
    repeat (4000) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) update_req = ~update_req;
      update_done = ($urandom_range(0, 49) == 0);
      reset       = ($urandom_range(0, 1499) == 0);
    end
    reset = 1'b0; update_req = 1'b0; update_done = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_scan_controller.md
Name: vga_scan_controller

Overview:
Sequences the VGA transmitter and generates the row/col scan position that feeds it: 800x525 total, 640x480 visible by default. Arbitrates frame-buffer write access for the game logic. An update is granted only inside vertical blanking, so game-state writes never tear a visible frame. Sits between the clock/reset root, the game FSM and vga_transmitter.

Parameters:
H_ACTIVE, 640, visible columns
H_TOTAL, 800, columns per line (active+FP+sync+BP)
V_ACTIVE, 480, visible rows
V_TOTAL, 525, rows per frame
CLK_DIV, 1, clk cycles per pixel (1..4); pixel_tick every CLK_DIV cycles

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
row  out  10  current scan row, 0..V_TOTAL-1, to transmitter
col  out  10  current scan column, 0..H_TOTAL-1, to transmitter
pixel_tick  out  1  one-clk strobe; row/col advance on the cycle after the strobe
active  out  1  row<V_ACTIVE && col<H_ACTIVE (combinational from row/col regs)
frame_start  out  1  one-clk pulse on the clk where row/col become 0/0
update_req  in  1  game requests frame-buffer write window; level, held until granted
update_grant  out  1  write window open
update_done  in  1  game finished writes; sampled only while update_grant=1
update_overrun  out  1  one-clk pulse when grant is revoked by end of blanking

Behaviour:
- Reset values: row=0, col=0, divider=0, pixel_tick=0, frame_start=0, update_grant=0, update_overrun=0, FSM=IDLE. reset has priority over all events.
- Divider: counts 0..CLK_DIV-1. pixel_tick=1 when divider==CLK_DIV-1. With CLK_DIV=1, pixel_tick is 1 every cycle after reset deasserts.
- Scan on each pixel_tick:
  - col increments.
  - At col==H_TOTAL-1: col wraps to 0 and row increments.
  - At row==V_TOTAL-1 && col==H_TOTAL-1: row wraps to 0 and frame_start pulses on the same edge.
  - Row/col never exceed TOTAL-1.
- Blanking window: vblank = row>=V_ACTIVE.
- FSM:
  - IDLE: update_req=1 -> WAIT.
  - WAIT: at the edge that sets row to V_ACTIVE with col=0 (start of vblank) -> GRANT, update_grant=1. A request raised while already in vblank waits for the next frame; no mid-blank grant.
  - GRANT: update_done=1 -> IDLE, update_grant=0 next cycle.
  - GRANT: wrap to row 0 without update_done -> IDLE, update_grant=0, update_overrun pulses 1 clk.
  - If update_done and the wrap occur on the same edge, done wins and there is no overrun.
- update_done outside GRANT is ignored. update_req deasserted while in WAIT -> return to IDLE.
- update_grant is never high while active=1.
- Reset mid-frame or mid-grant: grant drops on the next edge, scan restarts at 0/0, and no overrun pulse is issued.

Optional Feature:
VGA_FRAME_COUNTER_EN:
- Defined: adds output frame_count[7:0], reset 0, incremented on every frame_start, wraps 255->0. Lets the game pace snake speed by frames.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset held 3 clks, CLK_DIV=1, release -> row=0, col=0, grant=0. After 800 ticks row=1, col=0. After 420000 ticks frame_start pulses and row=col=0.
- CLK_DIV=2 -> pixel_tick every other clk. col=1 after 2 clks, and 840000 clks per frame.
- update_req=1 at row 100 -> grant rises when row becomes 480, col 0. update_done at row 490 -> grant=0 next clk, overrun=0.
- Grant with update_done never asserted -> grant falls and update_overrun pulses once on the wrap to row 0.
- update_done coincident with the wrap edge -> no overrun. update_req first raised at row 500 -> grant at row 480 of the next frame.
- reset asserted while grant=1 at row 510 -> grant=0, row=col=0, no overrun. With VGA_FRAME_COUNTER_EN, frame_count reads 0, then 1 after one full frame.
